// File: rtl/filterwheel_clk_reset_seq_if.sv
// Handshake bundle between the CCC lock/control inputs and the fabric reset sequencer.
// Bus side of filterwheel_clk_reset_seq; the sequencer binds the slave modport.
interface filterwheel_clk_reset_seq_if #(
    parameter int N_DOMAINS = 3
);
    logic                 pll_lock;
    logic                 sw_rst_req;
    logic                 cnt_clr;
    logic [N_DOMAINS-1:0] fabric_rst_n;
    logic                 ready;
    logic                 lock_sync;
    logic [7:0]           lock_loss_cnt;

    modport master (
        output pll_lock,
        output sw_rst_req,
        output cnt_clr,
        input  fabric_rst_n,
        input  ready,
        input  lock_sync,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_lock,
        input  sw_rst_req,
        input  cnt_clr,
        output fabric_rst_n,
        output ready,
        output lock_sync,
        output lock_loss_cnt
    );
endinterface

// File: rtl/filterwheel_clk_reset_seq.sv
// Fabric reset sequencer: waits for stable PLL lock, then releases domains in order.
// Optional lock-loss counter enabled by FILTERWHEEL_LOCK_LOSS_CNT_EN.
module filterwheel_clk_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int N_DOMAINS          = 3
) (
    input logic                       clk,
    input logic                       rst_n,
    filterwheel_clk_reset_seq_if.slave bus
);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES);
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN,
        LOST
    } state_t;

    state_t               state;
    logic                 lock_m;
    logic                 lock_s;
    logic [SW-1:0]        stab_cnt;
    logic [GW-1:0]        stage_cnt;
    logic [N_DOMAINS-1:0] fab_q;
    logic [N_DOMAINS-1:0] fab_next;
    logic                 ready_q;
    logic                 active;
    logic                 abort;
    logic                 loss;

    // Domains are released LSB first, so the next pattern shifts in a one.
    assign fab_next = (fab_q << 1) | N_DOMAINS'(1);
    assign active   = (state == RELEASE) || (state == RUN);
    assign loss     = active && !lock_s;
    assign abort    = active && (!lock_s || bus.sw_rst_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            state     <= WAIT_LOCK;
            stab_cnt  <= '0;
            stage_cnt <= '0;
            fab_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            lock_m <= bus.pll_lock;
            lock_s <= lock_m;
            if (abort) begin
                state     <= LOST;
                fab_q     <= '0;
                ready_q   <= 1'b0;
                stage_cnt <= '0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        stab_cnt <= '0;
                        if (lock_s) begin
                            state    <= STABILIZE;
                            stab_cnt <= SW'(1);
                        end
                    end
                    // A dropout while still stabilizing only restarts the count.
                    STABILIZE: begin
                        if (!lock_s) begin
                            state    <= WAIT_LOCK;
                            stab_cnt <= '0;
                        end else if (stab_cnt == STAB_LAST) begin
                            stab_cnt  <= '0;
                            stage_cnt <= '0;
                            fab_q[0]  <= 1'b1;
                            if (N_DOMAINS == 1) begin
                                state   <= RUN;
                                ready_q <= 1'b1;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            stab_cnt <= stab_cnt + SW'(1);
                        end
                    end
                    RELEASE: begin
                        if (stage_cnt == GAP_LAST) begin
                            stage_cnt <= '0;
                            fab_q     <= fab_next;
                            if (fab_next[N_DOMAINS-1]) begin
                                state   <= RUN;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            stage_cnt <= stage_cnt + GW'(1);
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    LOST: begin
                        if (stage_cnt == GAP_LAST) begin
                            state     <= WAIT_LOCK;
                            stage_cnt <= '0;
                        end else begin
                            stage_cnt <= stage_cnt + GW'(1);
                        end
                    end
                    default: state <= WAIT_LOCK;
                endcase
            end
        end
    end

    assign bus.fabric_rst_n = fab_q;
    assign bus.ready        = ready_q;
    assign bus.lock_sync    = lock_s;

`ifdef FILTERWHEEL_LOCK_LOSS_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (loss && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    logic unused_loss;

    assign unused_cnt_clr    = bus.cnt_clr;
    assign unused_loss       = loss;
    assign bus.lock_loss_cnt = '0;
`endif
endmodule

// File: tb/tb_filterwheel_clk_reset_seq.sv
// Bench for filterwheel_clk_reset_seq: directed scenarios plus random traffic
// checked against a timestamp-based reference model.
module tb_filterwheel_clk_reset_seq;
    localparam int LSC = 8;
    localparam int GAP = 4;
    localparam int ND  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    filterwheel_clk_reset_seq_if #(.N_DOMAINS(ND)) bus ();

    filterwheel_clk_reset_seq #(
        .LOCK_STABLE_CYCLES(LSC),
        .STAGE_GAP(GAP),
        .N_DOMAINS(ND)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting for LSC consecutive lock samples,
    // 1 = released for t_rel cycles, 2 = lost hold.
    int       ph = 0;
    int       run_n = 0;
    int       t_rel = 0;
    int       hold = 0;
    int       mcnt = 0;
    bit       mm = 0;
    bit       ms = 0;
    logic [ND-1:0] e_fab = '0;
    logic     e_ready = 1'b0;
    logic     e_sync = 1'b0;
    logic [7:0] e_cnt = '0;

    task automatic model_edge();
        bit lk;
        bit sw;
        bit clr;
        bit old_s;
        lk  = bus.pll_lock;
        sw  = bus.sw_rst_req;
        clr = bus.cnt_clr;
        if (!rst_n) begin
            ph = 0; run_n = 0; t_rel = 0; hold = 0;
            mcnt = 0; mm = 0; ms = 0;
        end else begin
            old_s = ms;
            if (clr) mcnt = 0;
            else if (ph == 1 && !old_s && mcnt < 255) mcnt = mcnt + 1;
            case (ph)
                0: begin
                    if (old_s) begin
                        run_n++;
                        if (run_n == LSC) begin
                            ph = 1; t_rel = 0; run_n = 0;
                        end
                    end else begin
                        run_n = 0;
                    end
                end
                1: begin
                    if (!old_s || sw) begin
                        ph = 2; hold = 0;
                    end else begin
                        t_rel++;
                    end
                end
                default: begin
                    hold++;
                    if (hold == GAP) begin
                        ph = 0; run_n = 0;
                    end
                end
            endcase
            ms = mm;
            mm = lk;
        end
        for (int k = 0; k < ND; k++)
            e_fab[k] = (ph == 1) && (t_rel >= k * GAP);
        e_ready = (ph == 1) && (t_rel >= (ND - 1) * GAP);
        e_sync  = ms;
`ifdef FILTERWHEEL_LOCK_LOSS_CNT_EN
        e_cnt = 8'(mcnt);
`else
        e_cnt = 8'd0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [12:0] obs_v();
        return {bus.fabric_rst_n, bus.ready, bus.lock_sync, bus.lock_loss_cnt};
    endfunction

    function automatic logic [12:0] exp_v();
        return {e_fab, e_ready, e_sync, e_cnt};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pll_lock = 1'b0;
        bus.sw_rst_req = 1'b0;
        bus.cnt_clr = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pll_lock   = 1'($urandom);
            bus.sw_rst_req = 1'($urandom);
            bus.cnt_clr    = 1'($urandom);
            step();
            total++;
            if (obs_v() !== 13'd0) begin
                bad++;
                $display("FAIL reset i=%0d got=%h want=%h", i, obs_v(), 13'd0);
            end
        end
    endtask

    task automatic test_clean_lock();
        logic [ND-1:0] xf;
        do_reset();
        bus.pll_lock = 1'b1;
        for (int e = 0; e < 22; e++) begin
            step();
            xf = (e < 9) ? 3'b000 : (e < 13) ? 3'b001 : (e < 17) ? 3'b011 : 3'b111;
            total++;
            if (bus.fabric_rst_n !== xf || bus.ready !== (e >= 17)
                || bus.lock_sync !== (e >= 1)) begin
                bad++;
                $display("FAIL clean_lock E%0d got fab=%b rdy=%b sync=%b want fab=%b rdy=%b sync=%b",
                         e, bus.fabric_rst_n, bus.ready, bus.lock_sync, xf, e >= 17, e >= 1);
            end
            total++;
            if (obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL clean_model E%0d got=%h want=%h", e, obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_unstable();
        do_reset();
        for (int e = 0; e < 28; e++) begin
            bus.pll_lock = (e != 5);
            step();
            total++;
            if (obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL unstable_model E%0d got=%h want=%h", e, obs_v(), exp_v());
            end
            if (e < 15) begin
                total++;
                if (bus.fabric_rst_n !== 3'b000 || bus.lock_loss_cnt !== 8'd0) begin
                    bad++;
                    $display("FAIL unstable_hold E%0d got fab=%b cnt=%0d want fab=000 cnt=0",
                             e, bus.fabric_rst_n, bus.lock_loss_cnt);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [7:0] xc;
`ifdef FILTERWHEEL_LOCK_LOSS_CNT_EN
        xc = 8'd1;
`else
        xc = 8'd0;
`endif
        do_reset();
        bus.pll_lock = 1'b1;
        repeat (20) step();
        for (int f = 0; f < 26; f++) begin
            bus.pll_lock = (f >= 3);
            step();
            total++;
            if (obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL loss_model F%0d got=%h want=%h", f, obs_v(), exp_v());
            end
            if (f == 1 || f == 2) begin
                total++;
                if (bus.fabric_rst_n !== ((f == 1) ? 3'b111 : 3'b000)
                    || bus.ready !== (f == 1)) begin
                    bad++;
                    $display("FAIL loss_edge F%0d got fab=%b rdy=%b", f, bus.fabric_rst_n, bus.ready);
                end
            end
            if (f == 2) begin
                total++;
                if (bus.lock_loss_cnt !== xc) begin
                    bad++;
                    $display("FAIL loss_cnt got=%0d want=%0d", bus.lock_loss_cnt, xc);
                end
            end
            if (f == 21 || f == 22) begin
                total++;
                if (bus.ready !== (f == 22)) begin
                    bad++;
                    $display("FAIL loss_rerun F%0d got rdy=%b want=%b", f, bus.ready, f == 22);
                end
            end
        end
    endtask

    task automatic test_sw_rst();
        do_reset();
        bus.pll_lock = 1'b1;
        repeat (20) step();
        for (int s = 0; s < 22; s++) begin
            bus.sw_rst_req = (s == 0);
            step();
            total++;
            if (obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL swrst_model S+%0d got=%h want=%h", s, obs_v(), exp_v());
            end
            if (s == 0 || s == 19 || s == 20) begin
                total++;
                if (bus.ready !== (s == 20) || bus.lock_loss_cnt !== 8'd0
                    || bus.fabric_rst_n !== ((s == 20) ? 3'b111 : (s == 0) ? 3'b000 : 3'b011)) begin
                    bad++;
                    $display("FAIL swrst S+%0d got fab=%b rdy=%b cnt=%0d",
                             s, bus.fabric_rst_n, bus.ready, bus.lock_loss_cnt);
                end
            end
        end
        bus.sw_rst_req = 1'b0;
    endtask

    task automatic test_saturation();
        logic [7:0] xc;
`ifdef FILTERWHEEL_LOCK_LOSS_CNT_EN
        xc = 8'd255;
`else
        xc = 8'd0;
`endif
        do_reset();
        for (int n = 0; n < 260; n++) begin
            for (int c = 0; c < 20; c++) begin
                bus.pll_lock = (c < 12);
                step();
                total++;
                if (obs_v() !== exp_v()) begin
                    bad++;
                    $display("FAIL sat_model n=%0d c=%0d got=%h want=%h", n, c, obs_v(), exp_v());
                end
            end
        end
        total++;
        if (bus.lock_loss_cnt !== xc) begin
            bad++;
            $display("FAIL sat_cnt got=%0d want=%0d", bus.lock_loss_cnt, xc);
        end
        bus.pll_lock = 1'b1;
        repeat (12) step();
        bus.pll_lock = 1'b0;
        step();
        step();
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
        total++;
        if (bus.lock_loss_cnt !== 8'd0 || bus.fabric_rst_n !== 3'b000) begin
            bad++;
            $display("FAIL clr_vs_inc got cnt=%0d fab=%b want cnt=0 fab=000",
                     bus.lock_loss_cnt, bus.fabric_rst_n);
        end
        total++;
        if (obs_v() !== exp_v()) begin
            bad++;
            $display("FAIL clr_model got=%h want=%h", obs_v(), exp_v());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.pll_lock = 1'b1;
        repeat (14) step();
        total++;
        if (bus.fabric_rst_n !== 3'b011) begin
            bad++;
            $display("FAIL mid_pre got fab=%b want 011", bus.fabric_rst_n);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if (obs_v() !== 13'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h want=%h", obs_v(), 13'd0);
        end
        for (int r = 1; r < 22; r++) begin
            step();
            total++;
            if (obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL mid_model R+%0d got=%h want=%h", r, obs_v(), exp_v());
            end
            if (r == 17 || r == 18) begin
                total++;
                if (bus.ready !== (r == 18)) begin
                    bad++;
                    $display("FAIL mid_rerun R+%0d got rdy=%b want=%b", r, bus.ready, r == 18);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.pll_lock = ~bus.pll_lock;
            bus.sw_rst_req = ($urandom_range(0, 59) == 0);
            bus.cnt_clr    = ($urandom_range(0, 199) == 0);
            rst_n          = ($urandom_range(0, 799) != 0);
            step();
            total++;
            if (obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL random i=%0d got=%h want=%h", i, obs_v(), exp_v());
            end
        end
        rst_n = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.cnt_clr = 1'b0;
    endtask

    initial begin
        bus.pll_lock   = 1'b0;
        bus.sw_rst_req = 1'b0;
        bus.cnt_clr    = 1'b0;
        test_reset();
        test_clean_lock();
        test_unstable();
        test_lock_loss();
        test_sw_rst();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
